pipeline_ctrl: RTL and testbench

Central pipeline controller that drives the `stall[5:0]` and `flush` inputs of every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb) and redirects fetch on exceptions. It merges per-stage stall requests into a prefix stall vector and takes exceptions reported by the MEM stage. It holds the exception state registers (EPC, cause, in-exception flag), times out a hung MEM-stage stall into a bus-timeout exception, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_ctrl_pkg.sv | 27 ++
 rtl/pipeline_ctrl_if.sv | 30 +++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/pipeline_ctrl.sv | 89 ++++++++
 tb/tb_pipeline_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall patterns, exception types
// and cause codes.
package pipeline_ctrl_pkg;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_SYSCALL = 2'b01,
    EXC_BREAK   = 2'b10,
    EXC_ERTN    = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_SYS  = 2'b01,
    CAUSE_BRK  = 2'b10,
    CAUSE_TMO  = 2'b11
  } cause_e;

  // Prefix patterns: every stage at or upstream of the requester stops.
  localparam logic [5:0] STALL_NONE = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
  localparam logic [5:0] STALL_IF   = {NoStop, NoStop, NoStop, NoStop, Stop,   Stop};
  localparam logic [5:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
  localparam logic [5:0] STALL_EX   = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};
  localparam logic [5:0] STALL_MEM  = {NoStop, Stop,   Stop,   Stop,   Stop,   Stop};
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline <-> controller bundle: stall requests and MEM-stage exception info in,
// stall/flush/redirect and exception state out.
interface pipeline_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        mem_inst_valid;
  logic [1:0]  mem_excepttype;
  logic [31:0] mem_current_inst_address;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] epc;
  logic        in_exception;
  logic [1:0]  cause;
  logic [31:0] stall_cycles;

  modport master (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
           mem_inst_valid, mem_excepttype, mem_current_inst_address,
    output stall, flush, new_pc, epc, in_exception, cause, stall_cycles
  );

  modport slave (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
           mem_inst_valid, mem_excepttype, mem_current_inst_address,
    input  stall, flush, new_pc, epc, in_exception, cause, stall_cycles
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a valid MEM instruction is stalled; flags the cycle
// that reaches TIMEOUT so the controller can raise a bus-timeout exception.
module mem_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stallreq_mem,
  input  logic i_mem_inst_valid,
  input  logic i_flush,
  output logic o_tmo
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tcnt;
  logic          w_qual;

  assign w_qual = i_stallreq_mem && i_mem_inst_valid;
  assign o_tmo  = w_qual && (r_tcnt == LAST);

  // The flush that the timeout itself raises also restarts the count.
  always_ff @(posedge clk) begin
    if (rst)                   r_tcnt <= '0;
    else if (w_qual && !i_flush) r_tcnt <= r_tcnt + 1'b1;
    else                       r_tcnt <= '0;
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: prefix stall merge, MEM-stage exception take,
// bus-timeout exception, exception state registers and stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EENTRY  = 32'h1c00_8000,
  parameter int          TIMEOUT = 255,
  parameter int          TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  pipeline_ctrl_if.master bus
);
  logic [31:0] r_epc;
  logic        r_in_exception;
  logic [1:0]  r_cause;
  logic [31:0] r_stall_cycles;

  logic        w_exc;
  logic        w_ertn;
  logic        w_tmo_hit;
  logic        w_tmo;
  logic        w_flush;
  logic [5:0]  w_stall;
  logic [31:0] w_new_pc;

  assign w_exc   = bus.mem_inst_valid && (bus.mem_excepttype != EXC_NONE);
  assign w_ertn  = w_exc && (bus.mem_excepttype == EXC_ERTN);
  // A real exception in the same slot outranks the timeout.
  assign w_tmo   = w_tmo_hit && (bus.mem_excepttype == EXC_NONE);
  assign w_flush = w_exc || w_tmo;

  mem_wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk              (clk),
    .rst              (rst),
    .i_stallreq_mem   (bus.stallreq_mem),
    .i_mem_inst_valid (bus.mem_inst_valid),
    .i_flush          (w_flush),
    .o_tmo            (w_tmo_hit)
  );

  always_comb begin
    w_stall = STALL_NONE;
    if (w_flush)               w_stall = STALL_NONE;
    else if (bus.stallreq_mem) w_stall = STALL_MEM;
    else if (bus.stallreq_ex)  w_stall = STALL_EX;
    else if (bus.stallreq_id)  w_stall = STALL_ID;
    else if (bus.stallreq_if)  w_stall = STALL_IF;
  end

  // ertn returns to the registered epc, never to this cycle's capture.
  always_comb begin
    w_new_pc = 32'h0;
    if (w_flush) w_new_pc = w_ertn ? r_epc : EENTRY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_epc          <= 32'h0;
      r_in_exception <= 1'b0;
      r_cause        <= CAUSE_NONE;
    end else if (w_ertn) begin
      r_in_exception <= 1'b0;
    end else if (w_exc) begin
      r_epc          <= bus.mem_current_inst_address;
      r_in_exception <= 1'b1;
      r_cause        <= (bus.mem_excepttype == EXC_BREAK) ? CAUSE_BRK : CAUSE_SYS;
    end else if (w_tmo) begin
      r_epc          <= bus.mem_current_inst_address;
      r_in_exception <= 1'b1;
      r_cause        <= CAUSE_TMO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cycles <= 32'h0;
    else if ((w_stall != STALL_NONE) && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = w_flush;
  assign bus.new_pc       = w_new_pc;
  assign bus.epc          = r_epc;
  assign bus.in_exception = r_in_exception;
  assign bus.cause        = r_cause;
  assign bus.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;
  localparam logic [31:0] EENTRY  = 32'h1c00_8000;
  localparam int          TIMEOUT = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.EENTRY(EENTRY), .TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: architectural registers plus the length of the current
  // run of stalled valid MEM cycles.
  logic [31:0] m_epc;
  logic        m_inexc;
  logic [1:0]  m_cause;
  longint      m_cyc;
  int          m_run;
  logic        last_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic rif, input logic rid, input logic rex,
                      input logic rmem, input logic vld, input logic [1:0] et,
                      input logic [31:0] addr);
    logic [5:0]  es;
    logic        exc, qual, tmo, fl;
    logic [31:0] npc;
    @(negedge clk);
    rst = r;
    bus.stallreq_if = rif;
    bus.stallreq_id = rid;
    bus.stallreq_ex = rex;
    bus.stallreq_mem = rmem;
    bus.mem_inst_valid = vld;
    bus.mem_excepttype = et;
    bus.mem_current_inst_address = addr;
    #1;
    exc  = vld && (et != 2'b00);
    qual = rmem && vld;
    tmo  = qual && (m_run == TIMEOUT - 1) && (et == 2'b00);
    fl   = exc || tmo;
    if (fl)        es = 6'b000000;
    else if (rmem) es = 6'b011111;
    else if (rex)  es = 6'b001111;
    else if (rid)  es = 6'b000111;
    else if (rif)  es = 6'b000011;
    else           es = 6'b000000;
    npc = !fl ? 32'h0 : (exc && et == 2'b11) ? m_epc : EENTRY;
    chk("stall", {26'h0, bus.stall}, {26'h0, es});
    chk("flush", {31'h0, bus.flush}, {31'h0, fl});
    chk("new_pc", bus.new_pc, npc);
    @(posedge clk);
    if (r) begin
      m_epc = 0; m_inexc = 0; m_cause = 0; m_cyc = 0; m_run = 0;
    end else begin
      if (es != 0 && m_cyc < 64'hFFFF_FFFF) m_cyc++;
      m_run = (qual && !fl) ? m_run + 1 : 0;
      if (exc && et == 2'b11) m_inexc = 0;
      else if (exc) begin m_epc = addr; m_inexc = 1; m_cause = et; end
      else if (tmo) begin m_epc = addr; m_inexc = 1; m_cause = 2'b11; end
    end
    #1;
    chk("epc", bus.epc, m_epc);
    chk("in_exc", {31'h0, bus.in_exception}, {31'h0, m_inexc});
    chk("cause", {30'h0, bus.cause}, {30'h0, m_cause});
    chk("stall_cycles", bus.stall_cycles, m_cyc[31:0]);
    last_flush = fl;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 2'b00, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic vld, rmem;
    logic [1:0] et;
    total = 0; bad = 0; last_flush = 0;
    m_epc = 0; m_inexc = 0; m_cause = 0; m_cyc = 0; m_run = 0;
    rst = 1;
    bus.stallreq_if = 0; bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.mem_inst_valid = 0; bus.mem_excepttype = 0; bus.mem_current_inst_address = 0;
    step(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_cyc", bus.stall_cycles, 32'h0);

    // stall merge
    step(0, 1, 1, 0, 0, 0, 2'b00, 32'h0);
    chk("merge_id", {26'h0, bus.stall}, 32'h07);
    step(0, 1, 1, 0, 1, 0, 2'b00, 32'h0);
    step(0, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    chk("merge_cnt", bus.stall_cycles, 32'd2);

    // syscall, then ertn back to it
    step(0, 0, 0, 1, 0, 1, 2'b01, 32'h1c00_0040);
    chk("sys_epc", bus.epc, 32'h1c00_0040);
    chk("sys_cause", {30'h0, bus.cause}, 32'd1);
    idle();
    step(0, 0, 0, 0, 0, 1, 2'b11, 32'h1c00_0100);
    chk("ertn_inexc", {31'h0, bus.in_exception}, 32'd0);
    chk("ertn_epc", bus.epc, 32'h1c00_0040);

    // timeout after exactly TIMEOUT cycles
    for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 1, 1, 2'b00, 32'h1c00_0200);
    chk("tmo_cause", {30'h0, bus.cause}, 32'd3);
    chk("tmo_epc", bus.epc, 32'h1c00_0200);
    idle();

    // drop at cycle 2 restarts the count
    step(0, 0, 0, 0, 1, 1, 2'b00, 32'h1c00_0300);
    step(0, 0, 0, 0, 0, 1, 2'b00, 32'h1c00_0300);
    for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 1, 1, 2'b00, 32'h1c00_0304);
    chk("tmo2_epc", bus.epc, 32'h1c00_0304);
    idle();

    // break collides with timeout: break wins
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, 1, 1, 2'b00, 32'h1c00_0400);
    step(0, 0, 0, 0, 1, 1, 2'b10, 32'h1c00_0404);
    chk("prio_cause", {30'h0, bus.cause}, 32'd2);
    idle();

    // reset on the same edge as a syscall
    step(0, 0, 1, 0, 0, 0, 2'b00, 32'h0);
    step(1, 0, 0, 0, 0, 1, 2'b01, 32'h1c00_0500);
    chk("rst_sys_epc", bus.epc, 32'h0);
    chk("rst_sys_inexc", {31'h0, bus.in_exception}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      vld  = last_flush ? 1'b0 : ($urandom_range(0, 9) < 8);
      rmem = ($urandom_range(0, 9) < 6);
      et   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(($urandom_range(0, 149) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           rmem, vld, et, $urandom & 32'hFFFF_FFFC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
